alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the core execute stage and a Hamming parity/decode helper engine.
- Round-robin grant with one accepted operation per cycle.
- Drives the ALU operand and opcode inputs and captures Out/Zero in a registered response slot.
- The response slot has a valid/ready handshake, so a slow consumer back-pressures every requester.

Parameters:
- W, 8, operand and result width (matches the ALU).
- Ops, 4, ALU opcode width.
- NREQ, 2, number of requesters (1..8).
- IDW, $clog2(NREQ) but at least 1, width of the requester id.
- IDLE_OP, 4'hF, opcode driven to the ALU when nothing is granted (unassigned code, so ALU Out=0).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B (shift amount for shift ops).
- req_op  in  NREQ*Ops  ALU opcode per requester.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- alu_a  out  W  to ALU InputA.
- alu_b  out  W  to ALU InputB.
- alu_op  out  Ops  to ALU OP.
- alu_out  in  W  from ALU Out.
- alu_zero  in  1  from ALU Zero.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that issued the result.
- rsp_data  out  W  captured ALU result.
- rsp_zero  out  1  captured Zero flag.

Behaviour:
- Reset (Reset=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - req_ready=0 while Reset is low.
- Slot state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY | (FULL & rsp_ready).
- Grant, combinational, no request-to-ready dependency loop on the response side:
  - When can_accept, req_ready has a single bit set: the first i with req_valid[i]=1, searching from last+1 upward modulo NREQ.
  - Otherwise req_ready=0.
- ALU drive, combinational:
  - When a grant exists, alu_a/alu_b/alu_op = the granted requester's fields.
  - Otherwise alu_a=0, alu_b=0, alu_op=IDLE_OP.
- Capture on the edge where a transfer occurs:
  - rsp_data<=alu_out, rsp_zero<=alu_zero, rsp_id<=grant index, rsp_valid<=1, last<=grant index.
  - Latency is exactly 1 cycle from the accept edge to rsp_valid=1.
- Drain: FULL & rsp_ready & no transfer -> rsp_valid<=0.
- Simultaneous drain and accept: the slot is overwritten with the new result and rsp_valid stays 1. Back-to-back throughput is 1 op/cycle.
- FULL & !rsp_ready:
  - All req_ready=0 and the response fields hold steady.
  - last is unchanged, and requesters keep their requests asserted.
- A requester may drop req_valid without a grant; nothing is recorded.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NREQ-1,0. Any requester is granted within NREQ accepted ops.
- Single requester active: it is granted every cycle; last simply stays at its index.
- Widths: no arithmetic inside the block; results are passed through unmodified.
- Reset asserted mid-operation: any pending response is discarded and the pointer returns to NREQ-1.

Optional Feature:
- ALU_ARB_STATS_EN defined:
  - Adds output stat_grants (NREQ*16): per-requester saturating count of accepted ops, holding at 16'hFFFF.
  - Adds output stat_stalls (16): saturating count of cycles where some req_valid=1 but can_accept=0.
  - Both counters reset to 0.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset, then req0 only, ADD with a=8'h05, b=8'h03:
  - req_ready=2'b01.
  - Next cycle rsp_valid=1, rsp_id=0, rsp_data=8'h08, rsp_zero=0.
- Both requesters valid continuously, rsp_ready=1, 6 cycles:
  - Grants alternate 0,1,0,1,0,1.
  - rsp_id follows one cycle later.
- req1 SUB with a=8'h2A, b=8'h2A, rsp_ready=0 held 3 cycles:
  - rsp_data=8'h00, rsp_zero=1 and held stable.
  - req_ready=0 throughout.
  - When rsp_ready rises, the pending request is granted the same cycle.
- Idle cycle with no req_valid: alu_op=IDLE_OP, alu_a=alu_b=0, rsp_valid drops after the drain.
- Reset pulled low while rsp_valid=1 and both requesting:
  - rsp_valid=0 immediately, with no clock edge needed.
  - After release, requester 0 is granted first.
- With ALU_ARB_STATS_EN, 3 grants to req0 plus 2 stalled cycles: stat_grants[15:0]=3, stat_stalls=2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a registered valid/ready response slot. Define ALU_ARB_STATS_EN for grant/stall counters.
module alu_arbiter #(
    parameter int              W       = 8,
    parameter int              Ops     = 4,
    parameter int              NREQ    = 2,
    parameter int              IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter logic [Ops-1:0]  IDLE_OP = 4'hF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*Ops-1:0] req_op,
    output logic [NREQ-1:0]     req_ready,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [Ops-1:0]      alu_op,
    input  logic [W-1:0]        alu_out,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data,
    output logic                rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]  stat_grants,
    output logic [15:0]         stat_stalls
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t    state_q, state_d;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           can_accept;
    logic           transfer;
    int             scan_idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = (int'(last_q) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        can_accept = (state_q == EMPTY) || rsp_ready;
        // Ready is held low throughout reset even though the slot reads as empty.
        transfer   = can_accept && grant_found && Reset;
        req_ready  = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = IDLE_OP;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
            alu_a                = req_a[grant_idx*W +: W];
            alu_b                = req_b[grant_idx*W +: W];
            alu_op               = req_op[grant_idx*Ops +: Ops];
            state_d              = FULL;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!Reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    assign rsp_valid = (state_q == FULL);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            last_q   <= IDW'(NREQ - 1);
        end else if (transfer) begin
            rsp_id   <= grant_idx;
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
            last_q   <= grant_idx;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: the counter array is a handful of flops, so it is reset like any register.
        if (!Reset) begin
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
            stat_stalls <= '0;
        end else begin
            if (transfer && grant_cnt[grant_idx] != 16'hFFFF)
                grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 16'd1;
            if (|req_valid && !can_accept && stat_stalls != 16'hFFFF)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grants[g*16 +: 16] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter; a bench-side ALU answers the
// arbiter and a spec-level slot/round-robin model predicts every output.
module tb_alu_arbiter;

    localparam int W    = 8;
    localparam int OPS  = 4;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam logic [OPS-1:0] IDLE = 4'hF;

    logic                Clk = 1'b0;
    logic                Reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [NREQ*OPS-1:0] req_op;
    logic [NREQ-1:0]     req_ready;
    logic [W-1:0]        alu_a, alu_b, alu_out;
    logic [OPS-1:0]      alu_op;
    logic                alu_zero;
    logic                rsp_valid, rsp_ready, rsp_zero;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_data;
`ifdef ALU_ARB_STATS_EN
    logic [NREQ*16-1:0]  stat_grants;
    logic [15:0]         stat_stalls;
`endif

    alu_arbiter #(.W(W), .Ops(OPS), .NREQ(NREQ), .IDW(IDW), .IDLE_OP(IDLE)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .req_ready(req_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    always #5 Clk = ~Clk;

    // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, others 0.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [OPS-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[2:0];
            4'd6:    return a >> b[2:0];
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_fn(alu_a, alu_b, alu_op);
        alu_zero = (alu_out == '0);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model of the response slot and round-robin pointer.
    int       m_last;
    bit       m_valid;
    int       m_id;
    bit [7:0] m_data;
    bit       m_zero;
    int       m_grants0;
    int       m_stalls;

    task automatic model_reset();
        m_last = NREQ - 1; m_valid = 0; m_id = 0; m_data = 0; m_zero = 0;
        m_grants0 = 0; m_stalls = 0;
    endtask

    function automatic int exp_grant();
        if (m_valid && !rsp_ready) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [OPS-1:0] op);
        req_valid[i]        = v;
        req_a[i*W +: W]     = a;
        req_b[i*W +: W]     = b;
        req_op[i*OPS +: OPS] = op;
    endtask

    // One clock: inputs are already set just after a negedge.
    task automatic step(output int g);
        logic [W-1:0] ga, gb;
        logic [OPS-1:0] gop;
        #1;
        g = exp_grant();
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
            ga = req_a[g*W +: W]; gb = req_b[g*W +: W]; gop = req_op[g*OPS +: OPS];
            check("alu_a", alu_a, ga);
            check("alu_b", alu_b, gb);
            check("alu_op", alu_op, gop);
        end else begin
            check("alu_a_idle", alu_a, 0);
            check("alu_b_idle", alu_b, 0);
            check("alu_op_idle", alu_op, IDLE);
        end
        if (|req_valid && m_valid && !rsp_ready) m_stalls++;
        @(posedge Clk);
        if (g >= 0) begin
            m_valid = 1; m_id = g; m_last = g;
            m_data  = alu_fn(ga, gb, gop);
            m_zero  = (m_data == 0);
            if (g == 0) m_grants0++;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
        check("rsp_valid", rsp_valid, m_valid);
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        check("rsp_zero", rsp_zero, m_zero);
        @(negedge Clk);
    endtask

    task automatic reset_dut();
        Reset = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_data", rsp_data, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        int g;
        Reset     = 1'b0;
        req_valid = '1;
        req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b1;
        model_reset();
        #2;
        check("por_req_ready", req_ready, 0);
        check("por_rsp_valid", rsp_valid, 0);
        check("por_rsp_id", rsp_id, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // req0 ADD 5+3.
        req_valid = '0;
        set_req(0, 1, 8'h05, 8'h03, 4'd0);
        step(g);
        check("t1_grant", g, 0);
        check("t1_data", rsp_data, 8'h08);
        check("t1_zero", rsp_zero, 0);

        // Alternation from a fresh pointer.
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1, 8'(k), 8'h10, 4'd0);
            set_req(1, 1, 8'h40, 8'(k), 4'd4);
            step(g);
            check("rr_order", g, k % 2);
            check("rr_rsp_id", rsp_id, k % 2);
        end

        // Drain with nothing requesting: idle ALU drive, slot empties.
        req_valid = '0;
        rsp_ready = 1'b1;
        step(g);
        check("idle_rsp_valid", rsp_valid, 0);

        // req1 SUB 2A-2A, then consumer stalls for 3 cycles.
        set_req(1, 1, 8'h2A, 8'h2A, 4'd1);
        rsp_ready = 1'b0;
        step(g);
        check("sub_grant", g, 1);
        set_req(1, 1, 8'h01, 8'h01, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step(g);
            check("stall_ready", req_ready, 0);
            check("stall_data", rsp_data, 8'h00);
            check("stall_zero", rsp_zero, 1);
        end
        rsp_ready = 1'b1;
        #1;
        check("release_ready", req_ready, 2'b10);
        step(g);
        check("release_data", rsp_data, 8'h02);

        // Asynchronous reset while full and both requesting.
        set_req(0, 1, 8'h11, 8'h22, 4'd3);
        step(g);
        check("pre_rst_valid", rsp_valid, 1);
        #3;
        Reset = 1'b0;
        #1;
        check("async_rsp_valid", rsp_valid, 0);
        check("async_req_ready", req_ready, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        step(g);
        check("post_rst_first", g, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                        4'($urandom_range(0, 15)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(g);
        end

`ifdef ALU_ARB_STATS_EN
        reset_dut();
        req_valid = '0;
        set_req(0, 1, 8'h01, 8'h02, 4'd0);
        rsp_ready = 1'b0;
        step(g);
        rsp_ready = 1'b1;
        step(g);
        step(g);
        rsp_ready = 1'b0;
        step(g);
        step(g);
        req_valid = '0;
        #1;
        check("stat_grants0", stat_grants[15:0], 3);
        check("stat_grants0_model", stat_grants[15:0], m_grants0);
        check("stat_grants1", stat_grants[31:16], 0);
        check("stat_stalls", stat_stalls, 2);
        check("stat_stalls_model", stat_stalls, m_stalls);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
